// File: rtl/gpp16_pkg.sv
// Shared definitions for the 16-bit general purpose processor datapath.
// Holds the multiply/divide opcode and state enums plus the default data width.
package gpp16_pkg;

  localparam int GPP_DATA_W = 16;

  typedef enum logic [1:0] {
    MULLO = 2'b00,
    MULHI = 2'b01,
    DIVQ  = 2'b10,
    DIVR  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit sitting between the register file
// read ports and its write port. Shift-add multiply (LSB first) and restoring
// divide (MSB first) share one accumulator/shift register pair and a counter,
// producing one result bit per cycle, then issue a single register-file write.
// Optional build macro MULDIV_EARLY_DZ_EN: a divide with a zero divisor skips
// the iteration phase and writes back on the cycle right after issue.
module muldiv_unit
  import gpp16_pkg::*;
#(
  parameter int bits = GPP_DATA_W,
  parameter int N    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [bits-1:0] op_a,
  input  logic [bits-1:0] op_b,
  input  logic [N-1:0]    wa_in,
  output logic            busy,
  output logic            done,
  output logic            dz,
  output logic [bits-1:0] WD3,
  output logic [N-1:0]    WA3,
  output logic            WE3
);

  localparam int CW = (bits > 1) ? $clog2(bits) : 1;

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      opIn;
  muldiv_op_t      opReg_q;
  logic [CW-1:0]   count_q;
  logic [bits-1:0] opA_q;
  logic [bits-1:0] opB_q;
  logic [N-1:0]    waddr_q;
  logic [bits:0]   accReg_q;
  logic [bits-1:0] shiftReg_q;
  logic [bits-1:0] wdata_q;
  logic [N-1:0]    wa3_q;
  logic            dz_q;

  logic            opInIsDiv;
  logic            isDiv;
  logic            selHigh;
  logic            lastIter;
  logic [bits:0]   mulSum;
  logic [bits:0]   mulAccNext;
  logic [bits-1:0] mulShNext;
  logic [bits:0]   divShifted;
  logic            divGe;
  logic [bits:0]   divRemNext;
  logic [bits-1:0] divQNext;
  logic [bits:0]   iterAcc;
  logic [bits-1:0] iterSh;
  logic [bits-1:0] iterResult;

  assign opIn      = muldiv_op_t'(op);
  assign opInIsDiv = (opIn == DIVQ) || (opIn == DIVR);
  assign isDiv     = (opReg_q == DIVQ) || (opReg_q == DIVR);
  assign selHigh   = (opReg_q == MULHI) || (opReg_q == DIVR);
  assign lastIter  = (count_q == CW'(bits - 1));

`ifdef MULDIV_EARLY_DZ_EN
  logic earlyDz;
  assign earlyDz = opInIsDiv && (op_b == '0);
`endif

  // One iteration of either algorithm, computed from the current register pair
  always_comb begin
    mulSum     = {1'b0, accReg_q[bits-1:0]} + (shiftReg_q[0] ? {1'b0, opA_q} : '0);
    mulAccNext = {1'b0, mulSum[bits:1]};
    mulShNext  = {mulSum[0], shiftReg_q[bits-1:1]};

    divShifted = {accReg_q[bits-1:0], shiftReg_q[bits-1]};
    divGe      = (divShifted >= {1'b0, opB_q});
    divRemNext = divGe ? (divShifted - {1'b0, opB_q}) : divShifted;
    divQNext   = {shiftReg_q[bits-2:0], divGe};

    iterAcc    = isDiv ? divRemNext : mulAccNext;
    iterSh     = isDiv ? divQNext   : mulShNext;
    iterResult = selHigh ? iterAcc[bits-1:0] : iterSh;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: issue, fixed-length iteration, single write-back cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_EARLY_DZ_EN
          state_d = earlyDz ? WB : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (lastIter) begin
          state_d = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status and write-port strobes decoded straight from the state register
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == WB);
    WE3  = (state_q == WB);
  end

  assign WD3 = wdata_q;
  assign WA3 = wa3_q;
  assign dz  = dz_q;

  // Operand capture, iteration datapath and held write-back values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg_q    <= MULLO;
      count_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      waddr_q    <= '0;
      accReg_q   <= '0;
      shiftReg_q <= '0;
      wdata_q    <= '0;
      wa3_q      <= '0;
      dz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opReg_q    <= opIn;
            opA_q      <= op_a;
            opB_q      <= op_b;
            waddr_q    <= wa_in;
            count_q    <= '0;
            accReg_q   <= '0;
            shiftReg_q <= opInIsDiv ? op_a : op_b;
`ifdef MULDIV_EARLY_DZ_EN
            if (earlyDz) begin
              wdata_q <= (opIn == DIVR) ? op_a : '1;
              wa3_q   <= wa_in;
              dz_q    <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          accReg_q   <= iterAcc;
          shiftReg_q <= iterSh;
          if (lastIter) begin
            wdata_q <= iterResult;
            wa3_q   <= waddr_q;
            dz_q    <= isDiv && (opB_q == '0);
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Expected write-backs (data, address,
// divide-by-zero flag and the edge count at which the write must appear) are
// queued when an operation is issued and compared when WE3 is observed.
// Honours MULDIV_EARLY_DZ_EN for the zero-divisor write-back latency.
module tb_muldiv_unit;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  addr;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  wa_in;
  logic        busy;
  logic        done;
  logic        dz;
  logic [15:0] WD3;
  logic [2:0]  WA3;
  logic        WE3;

  exp_t expQ[$];
  exp_t monE;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit #(.bits(16), .N(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .op_a (op_a),
    .op_b (op_b),
    .wa_in(wa_in),
    .busy (busy),
    .done (done),
    .dz   (dz),
    .WD3  (WD3),
    .WA3  (WA3),
    .WE3  (WE3)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to time write-backs relative to issue
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one operation at a negedge while the unit is idle and queue its result
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] wa);
    exp_t        e;
    logic [31:0] prod;
    int          lat;
    prod = {16'h0, a} * {16'h0, b};
    lat  = 16;
    case (o)
      2'b00: e.data = prod[15:0];
      2'b01: e.data = prod[31:16];
      2'b10: e.data = (b == 16'h0) ? 16'hFFFF : a / b;
      default: e.data = (b == 16'h0) ? a : a % b;
    endcase
    e.dz   = o[1] && (b == 16'h0);
`ifdef MULDIV_EARLY_DZ_EN
    if (e.dz) lat = 0;
`endif
    e.addr = wa;
    e.cyc  = cyc + 1 + lat;
    expQ.push_back(e);
    op    = o;
    op_a  = a;
    op_b  = b;
    wa_in = wa;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    wa_in = ~wa;
  endtask

  // Wait for the next observed write-back, bounded
  task automatic waitWrite(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (WE3 !== 1'b1 && n < 100);
    if (WE3 !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout no WE3 within %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    op_a  = 16'h0;
    op_b  = 16'h0;
    wa_in = 3'h0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (WE3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_we3 got %b want 0", WE3); end
    checks++; if (WD3 !== 16'h0) begin errors++; $display("[TB] FAIL reset_wd3 got %h want 0000", WD3); end
    checks++; if (WA3 !== 3'h0) begin errors++; $display("[TB] FAIL reset_wa3 got %0d want 0", WA3); end
    checks++; if (dz !== 1'b0) begin errors++; $display("[TB] FAIL reset_dz got %b want 0", dz); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    issue(2'b00, 16'd7, 16'd3, 3'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mul_busy_after_start got %b want 1", busy); end
    waitWrite("mullo_7x3"); @(negedge clk);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 3'd1); waitWrite("mullo_max"); @(negedge clk);
    issue(2'b01, 16'hFFFF, 16'hFFFF, 3'd2); waitWrite("mulhi_max"); @(negedge clk);
  endtask

  task automatic test_div();
    issue(2'b10, 16'd100, 16'd7, 3'd3); waitWrite("divq_100_7"); @(negedge clk);
    issue(2'b11, 16'd100, 16'd7, 3'd4); waitWrite("divr_100_7"); @(negedge clk);
  endtask

  task automatic test_div_zero();
    issue(2'b10, 16'h1234, 16'h0, 3'd6); waitWrite("divq_zero"); @(negedge clk);
    issue(2'b11, 16'h1234, 16'h0, 3'd7); waitWrite("divr_zero"); @(negedge clk);
  endtask

  task automatic test_ignore_start();
    issue(2'b00, 16'd300, 16'd41, 3'd2);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b10; op_a = 16'hBEEF; op_b = 16'd3; wa_in = 3'd7;
    @(negedge clk);
    start = 1'b0;
    waitWrite("ignore_run");
    start = 1'b1; op = 2'b01; op_a = 16'hAAAA; op_b = 16'h5555; wa_in = 3'd6;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_wb_start busy got %b want 0", busy); end
    repeat (25) @(negedge clk);
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL ignore_pending got %0d want 0", expQ.size()); end
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 16'hC350, 16'h1F40, 3'd1);
    waitWrite("b2b_first");
    @(negedge clk);
    issue(2'b11, 16'hFFFE, 16'd10, 3'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept busy got %b want 1", busy); end
    waitWrite("b2b_second");
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  o;
      logic [15:0] a;
      logic [15:0] b;
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = (i == 3) ? 16'h0 : ((i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom));
      issue(o, a, b, 3'($urandom_range(0, 7)));
      waitWrite("random");
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    bit   sawWrite = 0;
    issue(2'b00, 16'd1234, 16'd56, 3'd5);
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    checks++; if (WE3 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_we3 got %b want 0", WE3); end
    checks++; if (WD3 !== 16'h0) begin errors++; $display("[TB] FAIL midrst_wd3 got %h want 0000", WD3); end
    checks++; if (WA3 !== 3'h0) begin errors++; $display("[TB] FAIL midrst_wa3 got %0d want 0", WA3); end
    if (expQ.size() > 0) dropped = expQ.pop_front();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (WE3 === 1'b1) sawWrite = 1;
    end
    checks++; if (sawWrite) begin errors++; $display("[TB] FAIL midrst_no_write got write want none"); end
    issue(2'b10, 16'd5000, 16'd9, 3'd4);
    waitWrite("after_reset");
    @(negedge clk);
  endtask

  // Scoreboard monitor runs alongside the scenario sequence
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b0 && WE3 === 1'b1) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write WD3=%h WA3=%0d at cyc %0d", WD3, WA3, cyc);
          end else begin
            monE = expQ.pop_front();
            checks++; if (WD3 !== monE.data) begin errors++; $display("[TB] FAIL wb_data got %h want %h", WD3, monE.data); end
            checks++; if (WA3 !== monE.addr) begin errors++; $display("[TB] FAIL wb_addr got %0d want %0d", WA3, monE.addr); end
            checks++; if (dz !== monE.dz) begin errors++; $display("[TB] FAIL wb_dz got %b want %b", dz, monE.dz); end
            checks++; if (cyc != monE.cyc) begin errors++; $display("[TB] FAIL wb_timing got cyc %0d want %0d", cyc, monE.cyc); end
            checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wb_done_busy got %b%b want 11", done, busy); end
          end
        end
      end
    join_none

    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();

    repeat (3) @(negedge clk);
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL final_pending got %0d want 0", expQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
